// File: rtl/candidate_sorter.sv
// candidate_sorter
//   Collects scored angle samples during a stage and keeps the best N
//   (1..10) of them in a list sorted by descending score. When the last
//   sample of the stage arrives, the list is published on the cycle after,
//   together with a one-cycle sorted_rdy pulse.
//
// Ports
//   clk                     system clock, rising edge
//   rst                     asynchronous active-low reset
//   stage_trigger           clears the working list and returns to IDLE
//   compare_num[3:0]        number of candidates kept (latched on first sample)
//   score_valid             qualifies score/theta/phi
//   score_last              last sample of the stage (with score_valid)
//   score[16:0]             unsigned match score, larger is better
//   theta[11:0], phi[11:0]  angles of the sample
//   candidate_angle_buffer  published list, entry i = bits [(i+1)*24-1 -: 24]
//                           as {theta, phi}, entry 0 is the best
//   best_score[16:0]        published score of entry 0
//   sorted_rdy              one-cycle pulse when a new list is published
//   busy                    high while collecting
module candidate_sorter (
  input  logic         clk,
  input  logic         rst,
  input  logic         stage_trigger,
  input  logic [3:0]   compare_num,
  input  logic         score_valid,
  input  logic         score_last,
  input  logic [16:0]  score,
  input  logic [11:0]  theta,
  input  logic [11:0]  phi,
  output logic [239:0] candidate_angle_buffer,
  output logic [16:0]  best_score,
  output logic         sorted_rdy,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t      state;
  logic [3:0]  n_reg;
  logic [9:0]  slot_valid;
  logic [16:0] slot_score [10];
  logic [23:0] slot_angle [10];

  logic [3:0]  n_clamped;
  logic [3:0]  n_eff;
  logic [3:0]  ins_pos;
  logic [9:0]  nxt_valid;
  logic [16:0] nxt_score [10];
  logic [23:0] nxt_angle [10];

  // The list is kept sorted with valid entries packed at the top, so the
  // insert point is simply the number of entries scoring >= the new one.
  // Using >= places a new sample below equal scores (stable ties), and an
  // insert point of N means the sample loses to every kept entry.
  always_comb begin
    n_clamped = compare_num;
    if (compare_num == 4'd0)
      n_clamped = 4'd1;
    else if (compare_num > 4'd10)
      n_clamped = 4'd10;

    n_eff = (state == IDLE) ? n_clamped : n_reg;

    ins_pos = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (slot_valid[i] && (slot_score[i] >= score))
        ins_pos = ins_pos + 4'd1;
    end

    for (int i = 0; i < 10; i++) begin
      nxt_valid[i] = slot_valid[i];
      nxt_score[i] = slot_score[i];
      nxt_angle[i] = slot_angle[i];
      if (ins_pos < n_eff) begin
        if (4'(i) == ins_pos) begin
          nxt_valid[i] = 1'b1;
          nxt_score[i] = score;
          nxt_angle[i] = {theta, phi};
        end else if ((4'(i) > ins_pos) && (i > 0)) begin
          nxt_valid[i] = slot_valid[i-1];
          nxt_score[i] = slot_score[i-1];
          nxt_angle[i] = slot_angle[i-1];
        end
      end
      // Anything pushed past slot N-1 falls off the list.
      if (4'(i) >= n_eff)
        nxt_valid[i] = 1'b0;
    end
  end

  // Single FSM block: stage_trigger overrides everything, including a
  // publish pending in DONE. The working list is cleared whenever the
  // block returns to IDLE so a new stage always starts empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                  <= IDLE;
      n_reg                  <= 4'd1;
      slot_valid             <= '0;
      candidate_angle_buffer <= '0;
      best_score             <= '0;
      sorted_rdy             <= 1'b0;
      busy                   <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        slot_score[i] <= '0;
        slot_angle[i] <= '0;
      end
    end else begin
      sorted_rdy <= 1'b0;
      if (stage_trigger) begin
        state      <= IDLE;
        slot_valid <= '0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE, COLLECT: begin
            if (score_valid) begin
              if (state == IDLE)
                n_reg <= n_clamped;
              slot_valid <= nxt_valid;
              for (int i = 0; i < 10; i++) begin
                slot_score[i] <= nxt_score[i];
                slot_angle[i] <= nxt_angle[i];
              end
              state <= score_last ? DONE : COLLECT;
              busy  <= !score_last;
            end
          end
          DONE: begin
            for (int i = 0; i < 10; i++) begin
              candidate_angle_buffer[(i+1)*24-1 -: 24] <=
                (slot_valid[i] && (4'(i) < n_reg)) ? slot_angle[i] : 24'd0;
            end
            best_score <= slot_valid[0] ? slot_score[0] : 17'd0;
            sorted_rdy <= 1'b1;
            slot_valid <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_candidate_sorter.sv
// tb_candidate_sorter
//   Scoreboard bench for candidate_sorter: stimulus pushes the list it
//   expects to be published, and a monitor pops and compares whenever
//   sorted_rdy is seen.
module tb_candidate_sorter;

  logic         clk = 1'b0;
  logic         rst;
  logic         stageTrigger;
  logic [3:0]   compareNum;
  logic         scoreValid;
  logic         scoreLast;
  logic [16:0]  scoreIn;
  logic [11:0]  thetaIn;
  logic [11:0]  phiIn;
  logic [239:0] angleBuffer;
  logic [16:0]  bestScore;
  logic         sortedRdy;
  logic         busyOut;

  int errorCount = 0;
  int checkCount = 0;

  logic [239:0] expBufferQ[$];
  logic [16:0]  expBestQ[$];

  logic         watchEn = 1'b0;
  logic [239:0] watchValue;
  logic [239:0] expA;
  logic [239:0] expB;

  candidate_sorter dut (
    .clk                    (clk),
    .rst                    (rst),
    .stage_trigger          (stageTrigger),
    .compare_num            (compareNum),
    .score_valid            (scoreValid),
    .score_last             (scoreLast),
    .score                  (scoreIn),
    .theta                  (thetaIn),
    .phi                    (phiIn),
    .candidate_angle_buffer (angleBuffer),
    .best_score             (bestScore),
    .sorted_rdy             (sortedRdy),
    .busy                   (busyOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [239:0] actual,
                             input logic [239:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one sample; it is accepted on the next rising edge.
  task automatic applyStimulus(input logic [3:0] cn, input logic [16:0] s,
                               input logic [11:0] t, input logic [11:0] p,
                               input logic last);
    compareNum = cn;
    scoreIn    = s;
    thetaIn    = t;
    phiIn      = p;
    scoreLast  = last;
    scoreValid = 1'b1;
    @(posedge clk);
    #1;
    scoreValid = 1'b0;
    scoreLast  = 1'b0;
  endtask

  task automatic expectPublish(input logic [239:0] b, input logic [16:0] best);
    expBufferQ.push_back(b);
    expBestQ.push_back(best);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (expBufferQ.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (expBufferQ.size() != 0) begin
      checkOutput({name, "_timeout"}, 240'd1, 240'd0);
      expBufferQ.delete();
      expBestQ.delete();
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst === 1'b1 && sortedRdy === 1'b1) begin
      if (expBufferQ.size() == 0) begin
        checkOutput("unexpected_sorted_rdy", 240'd1, 240'd0);
      end else begin
        checkOutput("published_buffer", angleBuffer, expBufferQ.pop_front());
        checkOutput("published_best", 240'(bestScore), 240'(expBestQ.pop_front()));
      end
    end
  end

  // Published buffer must hold its old value until the new publish.
  always @(negedge clk) begin
    if (watchEn && sortedRdy !== 1'b1)
      checkOutput("held_buffer", angleBuffer, watchValue);
  end

  initial begin
    logic [239:0] e;
    int n;

    rst = 1'b0; stageTrigger = 1'b0; compareNum = '0; scoreValid = 1'b0;
    scoreLast = 1'b0; scoreIn = '0; thetaIn = '0; phiIn = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_buffer", angleBuffer, 240'd0);
    checkOutput("reset_best", 240'(bestScore), 240'd0);
    checkOutput("reset_rdy", 240'(sortedRdy), 240'd0);
    checkOutput("reset_busy", 240'(busyOut), 240'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // N=3, scores 5,9,7,9,1: ties keep arrival order.
    e = '0;
    e[23:0]  = {12'd2, 12'd20};
    e[47:24] = {12'd4, 12'd40};
    e[71:48] = {12'd3, 12'd30};
    expectPublish(e, 17'd9);
    expA = e;
    applyStimulus(3, 5, 1, 10, 0);
    @(negedge clk);
    checkOutput("busy_collect", 240'(busyOut), 240'd1);
    applyStimulus(3, 9, 2, 20, 0);
    applyStimulus(3, 7, 3, 30, 0);
    applyStimulus(3, 9, 4, 40, 0);
    applyStimulus(3, 1, 5, 50, 1);
    @(negedge clk);
    checkOutput("rdy_not_early", 240'(sortedRdy), 240'd0);
    checkOutput("busy_done", 240'(busyOut), 240'd0);
    @(negedge clk);
    checkOutput("rdy_latency", 240'(sortedRdy), 240'd1);
    @(negedge clk);
    checkOutput("rdy_one_cycle", 240'(sortedRdy), 240'd0);
    waitDrain("n3");

    // compare_num=0 behaves as N=1.
    e = '0;
    e[23:0] = {12'd8, 12'd80};
    expectPublish(e, 17'd8);
    applyStimulus(0, 3, 7, 70, 0);
    applyStimulus(0, 8, 8, 80, 1);
    waitDrain("n0");

    // compare_num=15 behaves as N=10; scores 2 and 1 fall off.
    e = '0;
    for (int i = 0; i < 10; i++)
      e[(i+1)*24-1 -: 24] = {12'(12 - i), 12'(112 - i)};
    expectPublish(e, 17'd12);
    expA = e;
    for (int s = 12; s >= 1; s--)
      applyStimulus(15, 17'(s), 12'(s), 12'(s + 100), s == 1);
    waitDrain("n15");

    // stage_trigger beats a coincident last sample.
    applyStimulus(2, 4, 9, 90, 0);
    applyStimulus(2, 5, 9, 91, 0);
    stageTrigger = 1'b1; scoreValid = 1'b1; scoreLast = 1'b1; scoreIn = 17'd6;
    @(posedge clk); #1;
    stageTrigger = 1'b0; scoreValid = 1'b0; scoreLast = 1'b0;
    @(negedge clk);
    checkOutput("trigger_busy", 240'(busyOut), 240'd0);
    checkOutput("trigger_rdy", 240'(sortedRdy), 240'd0);
    repeat (4) @(negedge clk);
    checkOutput("trigger_buffer_kept", angleBuffer, expA);

    // Asynchronous reset mid-collection, then a fresh 2-sample stage.
    applyStimulus(4, 6, 10, 100, 0);
    @(negedge clk);
    checkOutput("busy_before_reset", 240'(busyOut), 240'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_busy", 240'(busyOut), 240'd0);
    checkOutput("async_reset_buffer", angleBuffer, 240'd0);
    @(posedge clk); #1; rst = 1'b1;
    e = '0;
    e[23:0]  = {12'd22, 12'd220};
    e[47:24] = {12'd21, 12'd210};
    expectPublish(e, 17'd11);
    expB = e;
    applyStimulus(4, 3, 21, 210, 0);
    applyStimulus(4, 11, 22, 220, 1);
    waitDrain("after_reset");

    // Published list holds across a new collection until its publish.
    watchValue = expB;
    watchEn = 1'b1;
    e = '0;
    e[23:0]  = {12'd32, 12'd322};
    e[47:24] = {12'd31, 12'd311};
    expectPublish(e, 17'd2);
    applyStimulus(2, 1, 31, 311, 0);
    applyStimulus(2, 2, 32, 322, 1);
    n = 0;
    while (sortedRdy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    watchEn = 1'b0;
    if (sortedRdy !== 1'b1)
      checkOutput("hold_publish_timeout", 240'(sortedRdy), 240'd1);
    waitDrain("hold");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/candidate_sorter.md
CANDIDATE_SORTER -- requirements
Module: candidate_sorter

Interface
REQ-001 SHALL have no parameters. K=10 entries and 24-bit entries are fixed.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 stage_trigger  in  1  one-cycle pulse that clears the working list and returns the block to IDLE.
REQ-005 compare_num  in  4  number of candidates kept this stage; sampled on the first accepted sample.
REQ-006 score_valid  in  1  qualifies score, theta and phi for one cycle.
REQ-007 score_last  in  1  final sample of the stage; meaningful only with score_valid.
REQ-008 score  in  17  match score of the sample (unsigned; larger is better).
REQ-009 theta  in  12  theta of the sample.
REQ-010 phi  in  12  phi of the sample.
REQ-011 candidate_angle_buffer  out  240  published ranked list.
  - Entry i occupies bits [(i+1)*24-1 -: 24]: upper 12 bits theta, lower 12 bits phi.
  - Entry 0 is the best.
REQ-012 best_score  out  17  published score of entry 0.
REQ-013 sorted_rdy  out  1  one-cycle pulse when a new list is published.
REQ-014 busy  out  1  high while in COLLECT.

Function
REQ-015 The FSM SHALL have three states: IDLE, COLLECT, DONE.
  - IDLE->COLLECT on the first score_valid.
  - COLLECT->DONE on score_valid&score_last.
  - DONE->IDLE on the next cycle.
REQ-016 The first sample SHALL latch compare_num as N.
  - 0 is treated as 1; values >10 are treated as 10.
  - N is held until the next IDLE.
REQ-017 The working list SHALL hold N slots, each with {valid, score, theta, phi}, sorted descending by score.
REQ-018 Each accepted sample SHALL be inserted in one cycle.
  - Parallel compare against all slots.
  - Slots at and below the insert point shift down by one; the entry in slot N-1 is discarded.
REQ-019 Ties SHALL be stable: a new sample is placed below every existing entry with an equal score.
REQ-020 A sample whose score is <= the score of valid slot N-1 SHALL be dropped when all N slots are valid.
REQ-021 A sample SHALL always be inserted when an invalid slot exists, filling from the top.
REQ-022 On the edge that accepts score_last, that sample SHALL be inserted first.
  - On the next edge (entering DONE->IDLE) the working list is copied to the published registers.
  - sorted_rdy is high for exactly that one cycle.
  - Latency from score_last to sorted_rdy rising is 2 cycles.
REQ-023 Published registers SHALL change only at publish and reset; they are held across stage_trigger and new collection.
REQ-024 At publish, entries for slots >= N or invalid slots SHALL be written as zero; best_score SHALL be 0 if slot 0 is invalid.
REQ-025 stage_trigger SHALL take priority over everything in the same cycle.
  - The coincident sample is dropped.
  - The working list is invalidated and the FSM goes to IDLE.
  - A pending publish is cancelled.
REQ-026 score_valid SHALL be ignored while in DONE; score_last without score_valid SHALL be ignored.
REQ-027 busy SHALL be high in COLLECT only, including the cycle score_last is accepted.
REQ-028 All arithmetic SHALL be unsigned compares only; there are no wrap cases.

Reset
REQ-029 On rst low:
  - FSM goes to IDLE.
  - All working slots are invalid.
  - N=1.
  - candidate_angle_buffer=0, best_score=0, sorted_rdy=0, busy=0.
REQ-030 Reset SHALL take effect asynchronously mid-collection with no publish; operation resumes on the first clk edge after rst goes high.

Verification
REQ-031 N=3; send scores 5,9,7,9,1 (theta=1..5, phi=10..50), last on the fifth.
  -> sorted_rdy 2 cycles after the last sample.
  -> Entry0={2,20}, entry1={4,40}, entry2={3,30}, entries 3-9 zero, best_score=9.
REQ-032 compare_num=0 with score 3 then score 8 (last) -> only entry0 is nonzero, holding the score-8 angles.
REQ-033 compare_num=15 with 12 descending scores 12..1 -> 10 entries published; scores 2 and 1 are dropped.
REQ-034 stage_trigger coincident with score_valid&score_last mid-stage:
  -> No sorted_rdy, busy=0 the next cycle.
  -> The previously published buffer is unchanged.
REQ-035 Reset asserted during COLLECT, then a new 2-sample stage -> published list contains only the new stage's angles.
REQ-036 Publish list A, then collect stage B while sampling candidate_angle_buffer every cycle -> it equals A until B's sorted_rdy.
